// File: rtl/simmem_rsv_requester_pkg.sv
// Shared types and constants for the simmem response-bank reservation path.
//
// Contents:
//   - Default AXI field widths, reused by blocks that are not parameterised
//   - req_type_e       : which AXI request channel an instance serves (AR or AW)
//   - rsv_req_state_e  : states of the reservation requester FSM
//   - axi_addr_req_t   : address request payload at the default widths
//   - sat_inc32        : saturating 32-bit increment for statistics counters
package simmem_rsv_requester_pkg;

  localparam int unsigned DefNumIds    = 4;
  localparam int unsigned DefIdW       = 2;
  localparam int unsigned DefAddrW     = 32;
  localparam int unsigned DefBurstLenW = 8;
  localparam int unsigned DefIidW      = 5;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_type_e;

  typedef enum logic [1:0] {
    RSV_IDLE,
    RSV_RSV,
    RSV_FORK
  } rsv_req_state_e;

  typedef struct packed {
    logic [DefIdW-1:0]       id;
    logic [DefAddrW-1:0]     addr;
    logic [DefBurstLenW-1:0] burst_len;
  } axi_addr_req_t;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hffff_ffff) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/simmem_valid_fork.sv
// Two-way valid fork with per-branch done flags.
//
// While valid_i is high, each branch presents its valid until that branch has
// handshaked once. done_o pulses in the cycle the last outstanding handshake
// completes (possibly both at once), and both done flags clear at that point
// so the fork is ready for the next transaction.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i               upstream transaction present
//   a_valid_o, a_ready_i  branch A handshake
//   b_valid_o, b_ready_i  branch B handshake
//   done_o                both branches served; upstream may advance
module simmem_valid_fork (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic a_valid_o,
  input  logic a_ready_i,
  output logic b_valid_o,
  input  logic b_ready_i,
  output logic done_o
);

  logic a_done_q, a_done_d;
  logic b_done_q, b_done_d;
  logic a_hs, b_hs;

  always_comb begin
    a_valid_o = valid_i & ~a_done_q;
    b_valid_o = valid_i & ~b_done_q;
    a_hs      = a_valid_o & a_ready_i;
    b_hs      = b_valid_o & b_ready_i;
    done_o    = valid_i & (a_done_q | a_hs) & (b_done_q | b_hs);

    a_done_d = a_done_q | a_hs;
    b_done_d = b_done_q | b_hs;
    if (done_o) begin
      a_done_d = 1'b0;
      b_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
    end
  end

endmodule

// File: rtl/simmem_rsv_requester.sv
// Request-side initiator of the response-bank reservation interface for one
// AXI request channel (AR when ReqType=0, AW when ReqType=1).
//
// Flow: accept an address request (IDLE), reserve a bank slot and capture the
// returned internal identifier (RSV), then hand the request to the real memory
// controller and the delay calculator in parallel (FORK). Write instances
// reserve a single response slot, so their reserved burst length is forced to 0.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_*                         incoming address request (valid/ready)
//   rsv_req_id_onehot_o,
//   rsv_burst_len_o, rsv_*        reservation request to the response bank;
//                                 rsv_iid_i is valid with rsv_ready_i
//   mem_*                         request forwarded to the real memory controller
//   dc_*                          entry forwarded to the delay calculator
//   stat_accepted_o               (SIMMEM_RSV_REQUESTER_STATS_EN) accepted requests
//   stat_rsv_stall_o              (SIMMEM_RSV_REQUESTER_STATS_EN) RSV stall cycles
//
// Build option: define SIMMEM_RSV_REQUESTER_STATS_EN to add the two saturating
// 32-bit statistics counters and their ports.
module simmem_rsv_requester
  import simmem_rsv_requester_pkg::*;
#(
  parameter int unsigned ReqType   = 0,
  parameter int unsigned NumIds    = 4,
  parameter int unsigned IdW       = 2,
  parameter int unsigned AddrW     = 32,
  parameter int unsigned BurstLenW = 8,
  parameter int unsigned IidW      = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic [IdW-1:0]       req_id_i,
  input  logic [AddrW-1:0]     req_addr_i,
  input  logic [BurstLenW-1:0] req_burst_len_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,

  output logic [NumIds-1:0]    rsv_req_id_onehot_o,
  output logic [BurstLenW-1:0] rsv_burst_len_o,
  output logic                 rsv_valid_o,
  input  logic                 rsv_ready_i,
  input  logic [IidW-1:0]      rsv_iid_i,

  output logic [IdW-1:0]       mem_id_o,
  output logic [AddrW-1:0]     mem_addr_o,
  output logic [BurstLenW-1:0] mem_burst_len_o,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,

  output logic [IidW-1:0]      dc_iid_o,
  output logic [AddrW-1:0]     dc_addr_o,
  output logic [BurstLenW-1:0] dc_burst_len_o,
  output logic                 dc_valid_o,
  input  logic                 dc_ready_i
`ifdef SIMMEM_RSV_REQUESTER_STATS_EN
  ,
  output logic [31:0]          stat_accepted_o,
  output logic [31:0]          stat_rsv_stall_o
`endif
);

  localparam req_type_e ReqKind = (ReqType == 0) ? REQ_RD : REQ_WR;
  localparam bit IsWr = (ReqKind == REQ_WR);
  // One extra bit so NumIds == 2**IdW is representable for the range check.
  localparam logic [IdW:0] NumIdsW = (IdW + 1)'(NumIds);

  typedef struct packed {
    logic [IdW-1:0]       id;
    logic [AddrW-1:0]     addr;
    logic [BurstLenW-1:0] burst_len;
  } req_t;

  rsv_req_state_e state_q;
  req_t           req_q;
  logic [IidW-1:0] iid_q;

  logic accept;
  logic fork_valid;
  logic fork_done;

  ////////////////////
  // Control decode //
  ////////////////////

  // Handshake outputs depend only on state_q and rst_i, so there is no
  // combinational path from any downstream ready to req_ready_o.
  always_comb begin
    req_ready_o = ~rst_i & (state_q == RSV_IDLE);
    rsv_valid_o = ~rst_i & (state_q == RSV_RSV);
    fork_valid  = ~rst_i & (state_q == RSV_FORK);
    accept      = req_valid_i & req_ready_o;
  end

  /////////
  // FSM //
  /////////

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RSV_IDLE;
      req_q   <= '0;
      iid_q   <= '0;
    end else begin
      unique case (state_q)
        RSV_IDLE: begin
          if (req_valid_i) begin
            req_q.id        <= req_id_i;
            req_q.addr      <= req_addr_i;
            req_q.burst_len <= req_burst_len_i;
            state_q         <= RSV_RSV;
          end
        end
        // Waits as long as the bank is full; there is deliberately no timeout.
        RSV_RSV: begin
          if (rsv_ready_i) begin
            iid_q   <= rsv_iid_i;
            state_q <= RSV_FORK;
          end
        end
        RSV_FORK: begin
          if (fork_done) begin
            state_q <= RSV_IDLE;
          end
        end
        default: state_q <= RSV_IDLE;
      endcase
    end
  end

  //////////////////////
  // Reservation side //
  //////////////////////

  // An out-of-range id matches no bit, leaving the one-hot vector all zeros.
  always_comb begin
    rsv_req_id_onehot_o = '0;
    for (int unsigned i = 0; i < NumIds; i++) begin
      rsv_req_id_onehot_o[i] = (req_q.id == IdW'(i));
    end
  end

  // Writes produce a single response, so only one bank slot is reserved.
  assign rsv_burst_len_o = IsWr ? '0 : req_q.burst_len;

  ///////////////////////
  // Fork to mem / dc  //
  ///////////////////////

  simmem_valid_fork u_fork (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (fork_valid),
    .a_valid_o (mem_valid_o),
    .a_ready_i (mem_ready_i),
    .b_valid_o (dc_valid_o),
    .b_ready_i (dc_ready_i),
    .done_o    (fork_done)
  );

  assign mem_id_o        = req_q.id;
  assign mem_addr_o      = req_q.addr;
  assign mem_burst_len_o = req_q.burst_len;

  assign dc_iid_o        = iid_q;
  assign dc_addr_o       = req_q.addr;
  assign dc_burst_len_o  = IsWr ? '0 : req_q.burst_len;

  ////////////////
  // Assertions //
  ////////////////

  id_in_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
    accept |-> ({1'b0, req_id_i} < NumIdsW));

  ////////////////
  // Statistics //
  ////////////////

`ifdef SIMMEM_RSV_REQUESTER_STATS_EN
  logic [31:0] stat_accepted_q;
  logic [31:0] stat_rsv_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_accepted_q  <= '0;
      stat_rsv_stall_q <= '0;
    end else begin
      if (accept) begin
        stat_accepted_q <= sat_inc32(stat_accepted_q);
      end
      if (rsv_valid_o && !rsv_ready_i) begin
        stat_rsv_stall_q <= sat_inc32(stat_rsv_stall_q);
      end
    end
  end

  assign stat_accepted_o  = stat_accepted_q;
  assign stat_rsv_stall_o = stat_rsv_stall_q;
`endif

endmodule

// File: tb/tb_simmem_rsv_requester.sv
// Directed bench for simmem_rsv_requester: one read instance and one write
// instance sharing clock and reset, each scenario in its own task.
module tb_simmem_rsv_requester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Read instance
  logic [1:0]  rd_req_id;
  logic [31:0] rd_req_addr;
  logic [7:0]  rd_req_len;
  logic        rd_req_valid, rd_req_ready;
  logic [3:0]  rd_onehot;
  logic [7:0]  rd_rsv_len;
  logic        rd_rsv_valid, rd_rsv_ready;
  logic [4:0]  rd_rsv_iid;
  logic [1:0]  rd_mem_id;
  logic [31:0] rd_mem_addr;
  logic [7:0]  rd_mem_len;
  logic        rd_mem_valid, rd_mem_ready;
  logic [4:0]  rd_dc_iid;
  logic [31:0] rd_dc_addr;
  logic [7:0]  rd_dc_len;
  logic        rd_dc_valid, rd_dc_ready;
`ifdef SIMMEM_RSV_REQUESTER_STATS_EN
  logic [31:0] rd_stat_acc, rd_stat_stall, wr_stat_acc, wr_stat_stall;
`endif

  // Write instance
  logic [1:0]  wr_req_id;
  logic [31:0] wr_req_addr;
  logic [7:0]  wr_req_len;
  logic        wr_req_valid, wr_req_ready;
  logic [3:0]  wr_onehot;
  logic [7:0]  wr_rsv_len;
  logic        wr_rsv_valid, wr_rsv_ready;
  logic [4:0]  wr_rsv_iid;
  logic [1:0]  wr_mem_id;
  logic [31:0] wr_mem_addr;
  logic [7:0]  wr_mem_len;
  logic        wr_mem_valid, wr_mem_ready;
  logic [4:0]  wr_dc_iid;
  logic [31:0] wr_dc_addr;
  logic [7:0]  wr_dc_len;
  logic        wr_dc_valid, wr_dc_ready;

  simmem_rsv_requester #(
    .ReqType(0), .NumIds(4), .IdW(2), .AddrW(32), .BurstLenW(8), .IidW(5)
  ) u_rd (
    .clk_i(clk), .rst_i(rst),
    .req_id_i(rd_req_id), .req_addr_i(rd_req_addr), .req_burst_len_i(rd_req_len),
    .req_valid_i(rd_req_valid), .req_ready_o(rd_req_ready),
    .rsv_req_id_onehot_o(rd_onehot), .rsv_burst_len_o(rd_rsv_len),
    .rsv_valid_o(rd_rsv_valid), .rsv_ready_i(rd_rsv_ready), .rsv_iid_i(rd_rsv_iid),
    .mem_id_o(rd_mem_id), .mem_addr_o(rd_mem_addr), .mem_burst_len_o(rd_mem_len),
    .mem_valid_o(rd_mem_valid), .mem_ready_i(rd_mem_ready),
    .dc_iid_o(rd_dc_iid), .dc_addr_o(rd_dc_addr), .dc_burst_len_o(rd_dc_len),
    .dc_valid_o(rd_dc_valid), .dc_ready_i(rd_dc_ready)
`ifdef SIMMEM_RSV_REQUESTER_STATS_EN
    , .stat_accepted_o(rd_stat_acc), .stat_rsv_stall_o(rd_stat_stall)
`endif
  );

  simmem_rsv_requester #(
    .ReqType(1), .NumIds(4), .IdW(2), .AddrW(32), .BurstLenW(8), .IidW(5)
  ) u_wr (
    .clk_i(clk), .rst_i(rst),
    .req_id_i(wr_req_id), .req_addr_i(wr_req_addr), .req_burst_len_i(wr_req_len),
    .req_valid_i(wr_req_valid), .req_ready_o(wr_req_ready),
    .rsv_req_id_onehot_o(wr_onehot), .rsv_burst_len_o(wr_rsv_len),
    .rsv_valid_o(wr_rsv_valid), .rsv_ready_i(wr_rsv_ready), .rsv_iid_i(wr_rsv_iid),
    .mem_id_o(wr_mem_id), .mem_addr_o(wr_mem_addr), .mem_burst_len_o(wr_mem_len),
    .mem_valid_o(wr_mem_valid), .mem_ready_i(wr_mem_ready),
    .dc_iid_o(wr_dc_iid), .dc_addr_o(wr_dc_addr), .dc_burst_len_o(wr_dc_len),
    .dc_valid_o(wr_dc_valid), .dc_ready_i(wr_dc_ready)
`ifdef SIMMEM_RSV_REQUESTER_STATS_EN
    , .stat_accepted_o(wr_stat_acc), .stat_rsv_stall_o(wr_stat_stall)
`endif
  );

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++; if (rd_req_ready !== 1'b0) begin tests_failed++;
      $display("FAIL rst_req_ready: got %0h expected 0", rd_req_ready); end
    tests_run++; if ({rd_rsv_valid, rd_mem_valid, rd_dc_valid} !== 3'b000) begin tests_failed++;
      $display("FAIL rst_valids: got %b expected 000", {rd_rsv_valid, rd_mem_valid, rd_dc_valid}); end
    tests_run++; if (wr_req_ready !== 1'b0) begin tests_failed++;
      $display("FAIL rst_wr_req_ready: got %0h expected 0", wr_req_ready); end
    rst = 1'b0;
    #1;
    tests_run++; if (rd_req_ready !== 1'b1) begin tests_failed++;
      $display("FAIL idle_req_ready: got %0h expected 1", rd_req_ready); end
    tests_run++; if (rd_mem_addr !== 32'h0 || rd_dc_iid !== 5'h0) begin tests_failed++;
      $display("FAIL rst_payload: got addr=%h iid=%0d expected 0/0", rd_mem_addr, rd_dc_iid); end
`ifdef SIMMEM_RSV_REQUESTER_STATS_EN
    tests_run++; if (rd_stat_acc !== 32'd0 || rd_stat_stall !== 32'd0) begin tests_failed++;
      $display("FAIL rst_stats: got %0d/%0d expected 0/0", rd_stat_acc, rd_stat_stall); end
`endif
  endtask

  task automatic test_read();
    rd_req_id = 2'd2; rd_req_addr = 32'h1000; rd_req_len = 8'd7; rd_req_valid = 1'b1;
    rd_rsv_ready = 1'b1; rd_rsv_iid = 5'd9; rd_mem_ready = 1'b1; rd_dc_ready = 1'b1;
    #1;
    tests_run++; if (rd_req_ready !== 1'b1) begin tests_failed++;
      $display("FAIL rd_c0_ready: got %0h expected 1", rd_req_ready); end
    tick();
    rd_req_valid = 1'b0;
    tests_run++; if (rd_rsv_valid !== 1'b1 || rd_onehot !== 4'b0100) begin tests_failed++;
      $display("FAIL rd_c1_rsv: got v=%0h oh=%b expected 1/0100", rd_rsv_valid, rd_onehot); end
    tests_run++; if (rd_rsv_len !== 8'd7 || rd_req_ready !== 1'b0) begin tests_failed++;
      $display("FAIL rd_c1_len: got len=%0d rdy=%0h expected 7/0", rd_rsv_len, rd_req_ready); end
    tick();
    tests_run++; if (rd_mem_valid !== 1'b1 || rd_dc_valid !== 1'b1) begin tests_failed++;
      $display("FAIL rd_c2_valids: got %0h/%0h expected 1/1", rd_mem_valid, rd_dc_valid); end
    tests_run++; if (rd_dc_iid !== 5'd9 || rd_mem_addr !== 32'h1000) begin tests_failed++;
      $display("FAIL rd_c2_payload: got iid=%0d addr=%h expected 9/1000", rd_dc_iid, rd_mem_addr); end
    tests_run++; if (rd_mem_id !== 2'd2 || rd_mem_len !== 8'd7 || rd_dc_len !== 8'd7 ||
                     rd_dc_addr !== 32'h1000) begin tests_failed++;
      $display("FAIL rd_c2_fields: got id=%0d ml=%0d dl=%0d da=%h expected 2/7/7/1000",
               rd_mem_id, rd_mem_len, rd_dc_len, rd_dc_addr); end
    tick();
    tests_run++; if (rd_req_ready !== 1'b1 || rd_mem_valid !== 1'b0 || rd_dc_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_c3_idle: got rdy=%0h mv=%0h dv=%0h expected 1/0/0",
               rd_req_ready, rd_mem_valid, rd_dc_valid); end
  endtask

  task automatic test_write();
    wr_req_id = 2'd3; wr_req_addr = 32'h2000; wr_req_len = 8'd15; wr_req_valid = 1'b1;
    wr_rsv_ready = 1'b1; wr_rsv_iid = 5'd17; wr_mem_ready = 1'b1; wr_dc_ready = 1'b1;
    tick();
    wr_req_valid = 1'b0;
    tests_run++; if (wr_rsv_len !== 8'd0 || wr_onehot !== 4'b1000) begin tests_failed++;
      $display("FAIL wr_c1_rsv: got len=%0d oh=%b expected 0/1000", wr_rsv_len, wr_onehot); end
    tick();
    tests_run++; if (wr_dc_len !== 8'd0 || wr_mem_len !== 8'd15) begin tests_failed++;
      $display("FAIL wr_c2_len: got dl=%0d ml=%0d expected 0/15", wr_dc_len, wr_mem_len); end
    tests_run++; if (wr_dc_iid !== 5'd17 || wr_mem_valid !== 1'b1) begin tests_failed++;
      $display("FAIL wr_c2_iid: got iid=%0d mv=%0h expected 17/1", wr_dc_iid, wr_mem_valid); end
    tick();
    tests_run++; if (wr_req_ready !== 1'b1) begin tests_failed++;
      $display("FAIL wr_c3_ready: got %0h expected 1", wr_req_ready); end
  endtask

  task automatic test_rsv_stall();
    rd_req_id = 2'd1; rd_req_addr = 32'h3000; rd_req_len = 8'd3; rd_req_valid = 1'b1;
    rd_rsv_ready = 1'b0; rd_rsv_iid = 5'd4; rd_mem_ready = 1'b1; rd_dc_ready = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (rd_rsv_valid !== 1'b1 || rd_onehot !== 4'b0010 || rd_req_ready !== 1'b0 ||
          rd_rsv_len !== 8'd3) begin
        tests_failed++;
        $display("FAIL stall_c%0d: got v=%0h oh=%b rdy=%0h len=%0d expected 1/0010/0/3",
                 i, rd_rsv_valid, rd_onehot, rd_req_ready, rd_rsv_len);
      end
      tick();
    end
    rd_rsv_ready = 1'b1;
`ifdef SIMMEM_RSV_REQUESTER_STATS_EN
    tests_run++; if (rd_stat_stall !== 32'd10) begin tests_failed++;
      $display("FAIL stat_stall: got %0d expected 10", rd_stat_stall); end
    tests_run++; if (rd_stat_acc !== 32'd2) begin tests_failed++;
      $display("FAIL stat_accepted: got %0d expected 2", rd_stat_acc); end
`endif
    tick();
    tests_run++; if (rd_dc_iid !== 5'd4 || rd_dc_valid !== 1'b1) begin tests_failed++;
      $display("FAIL stall_fork: got iid=%0d dv=%0h expected 4/1", rd_dc_iid, rd_dc_valid); end
    tick();
    tests_run++; if (rd_req_ready !== 1'b1) begin tests_failed++;
      $display("FAIL stall_idle: got %0h expected 1", rd_req_ready); end
  endtask

  task automatic test_fork_partial();
    int mem_hs;
    mem_hs = 0;
    rd_req_id = 2'd0; rd_req_addr = 32'h4000; rd_req_len = 8'd1; rd_req_valid = 1'b1;
    rd_rsv_ready = 1'b1; rd_rsv_iid = 5'd6; rd_mem_ready = 1'b1; rd_dc_ready = 1'b0;
    tick();
    rd_req_valid = 1'b0;
    tick();
    tests_run++; if (rd_mem_valid !== 1'b1 || rd_dc_valid !== 1'b1) begin tests_failed++;
      $display("FAIL fork_c0: got mv=%0h dv=%0h expected 1/1", rd_mem_valid, rd_dc_valid); end
    if (rd_mem_valid && rd_mem_ready) mem_hs++;
    tick();
    for (int c = 1; c < 4; c++) begin
      tests_run++;
      if (rd_mem_valid !== 1'b0 || rd_dc_valid !== 1'b1 || rd_dc_addr !== 32'h4000) begin
        tests_failed++;
        $display("FAIL fork_c%0d: got mv=%0h dv=%0h da=%h expected 0/1/4000",
                 c, rd_mem_valid, rd_dc_valid, rd_dc_addr);
      end
      if (rd_mem_valid && rd_mem_ready) mem_hs++;
      tick();
    end
    rd_dc_ready = 1'b1;
    #1;
    tests_run++; if (rd_dc_valid !== 1'b1 || rd_req_ready !== 1'b0) begin tests_failed++;
      $display("FAIL fork_c4: got dv=%0h rdy=%0h expected 1/0", rd_dc_valid, rd_req_ready); end
    if (rd_mem_valid && rd_mem_ready) mem_hs++;
    tick();
    rd_dc_ready = 1'b0;
    tests_run++; if (rd_req_ready !== 1'b1 || rd_dc_valid !== 1'b0) begin tests_failed++;
      $display("FAIL fork_exit: got rdy=%0h dv=%0h expected 1/0", rd_req_ready, rd_dc_valid); end
    tests_run++; if (mem_hs !== 1) begin tests_failed++;
      $display("FAIL fork_mem_hs: got %0d expected 1", mem_hs); end
  endtask

  task automatic test_reset_fork();
    rd_req_id = 2'd3; rd_req_addr = 32'h5000; rd_req_len = 8'd2; rd_req_valid = 1'b1;
    rd_rsv_ready = 1'b1; rd_rsv_iid = 5'd11; rd_mem_ready = 1'b1; rd_dc_ready = 1'b0;
    tick();
    rd_req_valid = 1'b0;
    tick();
    tick();
    // mem branch has completed, dc still outstanding
    tests_run++; if (rd_mem_valid !== 1'b0 || rd_dc_valid !== 1'b1) begin tests_failed++;
      $display("FAIL rstf_pre: got mv=%0h dv=%0h expected 0/1", rd_mem_valid, rd_dc_valid); end
    rst = 1'b1;
    tick();
    tests_run++; if ({rd_rsv_valid, rd_mem_valid, rd_dc_valid, rd_req_ready} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rstf_valids: got %b expected 0000",
               {rd_rsv_valid, rd_mem_valid, rd_dc_valid, rd_req_ready}); end
    rst = 1'b0;
    #1;
    tests_run++; if (rd_req_ready !== 1'b1 || rd_mem_valid !== 1'b0) begin tests_failed++;
      $display("FAIL rstf_idle: got rdy=%0h mv=%0h expected 1/0", rd_req_ready, rd_mem_valid); end
    rd_req_id = 2'd1; rd_req_addr = 32'h6000; rd_req_len = 8'd0; rd_req_valid = 1'b1;
    rd_rsv_iid = 5'd21; rd_mem_ready = 1'b1; rd_dc_ready = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    tests_run++; if (rd_onehot !== 4'b0010 || rd_rsv_valid !== 1'b1) begin tests_failed++;
      $display("FAIL rstf_onehot: got oh=%b v=%0h expected 0010/1", rd_onehot, rd_rsv_valid); end
    tick();
    tests_run++; if (rd_dc_iid !== 5'd21 || rd_mem_id !== 2'd1) begin tests_failed++;
      $display("FAIL rstf_iid: got iid=%0d id=%0d expected 21/1", rd_dc_iid, rd_mem_id); end
    tests_run++; if (rd_mem_valid !== 1'b1 || rd_dc_valid !== 1'b1) begin tests_failed++;
      $display("FAIL rstf_done_cleared: got mv=%0h dv=%0h expected 1/1",
               rd_mem_valid, rd_dc_valid); end
    tick();
    tests_run++; if (rd_req_ready !== 1'b1) begin tests_failed++;
      $display("FAIL rstf_final_idle: got %0h expected 1", rd_req_ready); end
  endtask

  initial begin
    rd_req_id = '0; rd_req_addr = '0; rd_req_len = '0; rd_req_valid = 1'b0;
    rd_rsv_ready = 1'b0; rd_rsv_iid = '0; rd_mem_ready = 1'b0; rd_dc_ready = 1'b0;
    wr_req_id = '0; wr_req_addr = '0; wr_req_len = '0; wr_req_valid = 1'b0;
    wr_rsv_ready = 1'b0; wr_rsv_iid = '0; wr_mem_ready = 1'b0; wr_dc_ready = 1'b0;

    test_reset();
    test_read();
    test_write();
    test_rsv_stall();
    test_fork_partial();
    test_reset_fork();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
